// File: rtl/fft_mag_writer.sv
// fft_mag_writer: writer side of the FFT output RAM.
// Accepts (re, im, idx) bins over valid/ready, computes an alpha-max-beta-min
// magnitude (max + min/2) in a 3-stage pipeline and writes it to the RAM port.
// Pulses frame_done once SIZE bins have been accepted and written.
// Optional macro FFT_MAG_WRITER_BITREV_EN: write address is the bit-reverse of
// in_idx (natural-order RAM for in-place DIF output); otherwise in_idx as is.
module fft_mag_writer #(
  parameter int SIZE = 64,
  parameter int DW   = 32,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic [AW-1:0] in_idx,
  output logic          o_wea,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_din,
  output logic          busy,
  output logic          frame_done,
  output logic          dup_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW:0] SIZE_C = (AW+1)'(SIZE);
  localparam logic [AW:0] LAST_C = (AW+1)'(SIZE - 1);

  state_t          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [SIZE-1:0] mask_q, mask_d;
  logic            dup_q, dup_d;
  logic            ready_q, ready_d;

  // stage 1: absolute values
  logic            s1_v_q, s1_v_d;
  logic [DW-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [AW-1:0]   s1_addr_q, s1_addr_d;
  // stage 2: max / min
  logic            s2_v_q, s2_v_d;
  logic [DW-1:0]   s2_mx_q, s2_mx_d, s2_mn_q, s2_mn_d;
  logic [AW-1:0]   s2_addr_q, s2_addr_d;
  // stage 3: magnitude, drives the RAM port
  logic            s3_v_q, s3_v_d;
  logic [DW-1:0]   s3_din_q, s3_din_d;
  logic [AW-1:0]   s3_addr_q, s3_addr_d;

  logic            accept;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   abs_re, abs_im;
  logic [DW:0]     mag_sum;

  // Write address: bit-reversed index or the index itself
  genvar gi;
  generate
`ifdef FFT_MAG_WRITER_BITREV_EN
    for (gi = 0; gi < AW; gi++) begin : g_rev
      assign waddr[gi] = in_idx[AW-1-gi];
    end
`else
    for (gi = 0; gi < AW; gi++) begin : g_pass
      assign waddr[gi] = in_idx[gi];
    end
`endif
  endgenerate

  // ready_q is only ever high in RUN, so it alone qualifies an accept
  assign accept = in_valid & ready_q;

  // Two's complement absolute value; -2^(DW-1) maps to 2^(DW-1) unsigned
  assign abs_re = in_re[DW-1] ? (~in_re + DW'(1)) : in_re;
  assign abs_im = in_im[DW-1] ? (~in_im + DW'(1)) : in_im;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && count_q == LAST_C) state_d = DRAIN;
      // Once stages 1 and 2 are empty the final write is on the port now
      DRAIN:   if (!s1_v_q && !s2_v_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and the output stage
  always_comb begin
    busy       = (state_q == RUN) || (state_q == DRAIN);
    frame_done = (state_q == DONE);
    in_ready   = ready_q;
    dup_err    = dup_q;
    o_wea      = s3_v_q;
    o_addr     = s3_addr_q;
    o_din      = s3_din_q;
  end

  // Frame bookkeeping: accept count, written mask, duplicate flag, ready
  always_comb begin
    count_d = count_q;
    mask_d  = mask_q;
    dup_d   = dup_q;
    if (state_q == IDLE && start) begin
      count_d = '0;
      mask_d  = '0;
      dup_d   = 1'b0;
    end
    if (accept) begin
      count_d = count_q + 1'b1;
      if (mask_q[waddr]) dup_d = 1'b1;
      mask_d[waddr] = 1'b1;
    end
    ready_d = (state_d == RUN) && (count_d < SIZE_C);
  end

  // Magnitude pipeline: each stage loads only when its predecessor is valid
  always_comb begin
    s1_v_d    = accept;
    s1_a_d    = accept ? abs_re : s1_a_q;
    s1_b_d    = accept ? abs_im : s1_b_q;
    s1_addr_d = accept ? waddr  : s1_addr_q;

    s2_v_d    = s1_v_q;
    s2_mx_d   = s2_mx_q;
    s2_mn_d   = s2_mn_q;
    s2_addr_d = s2_addr_q;
    if (s1_v_q) begin
      s2_mx_d   = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
      s2_mn_d   = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;
      s2_addr_d = s1_addr_q;
    end

    mag_sum   = {1'b0, s2_mx_q} + {2'b00, s2_mn_q[DW-1:1]};
    s3_v_d    = s2_v_q;
    s3_din_d  = s3_din_q;
    s3_addr_d = s3_addr_q;
    if (s2_v_q) begin
      s3_din_d  = mag_sum[DW] ? {DW{1'b1}} : mag_sum[DW-1:0];
      s3_addr_d = s2_addr_q;
    end
  end

  // Datapath and bookkeeping registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      mask_q    <= '0;
      dup_q     <= 1'b0;
      ready_q   <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_addr_q <= '0;
      s2_v_q    <= 1'b0;
      s2_mx_q   <= '0;
      s2_mn_q   <= '0;
      s2_addr_q <= '0;
      s3_v_q    <= 1'b0;
      s3_din_q  <= '0;
      s3_addr_q <= '0;
    end else begin
      count_q   <= count_d;
      mask_q    <= mask_d;
      dup_q     <= dup_d;
      ready_q   <= ready_d;
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_addr_q <= s1_addr_d;
      s2_v_q    <= s2_v_d;
      s2_mx_q   <= s2_mx_d;
      s2_mn_q   <= s2_mn_d;
      s2_addr_q <= s2_addr_d;
      s3_v_q    <= s3_v_d;
      s3_din_q  <= s3_din_d;
      s3_addr_q <= s3_addr_d;
    end
  end

endmodule

// File: tb/tb_fft_mag_writer.sv
// Self-checking bench for fft_mag_writer: randomized frames, a reference
// magnitude model and an in-order scoreboard checked by an output monitor.
module tb_fft_mag_writer;
  localparam int SIZE = 64;
  localparam int DW   = 32;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic [AW-1:0] in_idx = '0;
  logic          o_wea;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_din;
  logic          busy;
  logic          frame_done;
  logic          dup_err;

  fft_mag_writer #(.SIZE(SIZE), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_idx(in_idx),
    .o_wea(o_wea), .o_addr(o_addr), .o_din(o_din),
    .busy(busy), .frame_done(frame_done), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     addr;
    longint din;
    int     at;
  } exp_t;

  exp_t   sbq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     frames_seen = 0;
  int     last_wea = -10;
  bit     exp_dup = 1'b0;
  bit     exp_dup_nx = 1'b0;
  bit     dup_mon_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected RAM address for a bin index
  function automatic int ref_addr(input int idx);
    int r;
`ifdef FFT_MAG_WRITER_BITREV_EN
    r = 0;
    for (int i = 0; i < AW; i++) if (idx[i]) r += 1 << (AW - 1 - i);
`else
    r = idx;
`endif
    return r;
  endfunction

  // Reference magnitude: max(|re|,|im|) + floor(min/2), clipped to 2^32-1
  function automatic longint ref_mag(input logic [DW-1:0] re, input logic [DW-1:0] im);
    longint r, i, a, b, mx, mn, s;
    r = $signed(re);
    i = $signed(im);
    a = (r < 0) ? -r : r;
    b = (i < 0) ? -i : i;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    s = mx + mn / 2;
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the sticky duplicate flag, advanced on each clock edge
  always @(posedge clk) exp_dup <= rst ? exp_dup_nx : 1'b0;

  // Output monitor: pop the scoreboard on every write, check done timing
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (o_wea) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d din %0h expected no write (cycle %0d)",
                   o_addr, o_din, cyc);
        end else begin
          e = sbq.pop_front();
          chk("write_addr", longint'(o_addr), longint'(e.addr));
          chk("write_din", longint'(o_din), e.din);
          chk("write_cycle", longint'(cyc), longint'(e.at));
        end
        last_wea = cyc;
      end
      if (frame_done) begin
        frames_seen++;
        chk("frame_done_cycle", longint'(cyc), longint'(last_wea + 1));
      end
      if (dup_mon_en) chk("dup_err", longint'(dup_err), longint'(exp_dup));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_wea"}, longint'(o_wea), 0);
    chk({tag, "_addr"}, longint'(o_addr), 0);
    chk({tag, "_din"}, longint'(o_din), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(frame_done), 0);
    chk({tag, "_dup"}, longint'(dup_err), 0);
    chk({tag, "_ready"}, longint'(in_ready), 0);
  endtask

  // One frame: pat selects data, gaps makes in_valid run 1,0,0,1,
  // abort resets the block while two writes are still in the pipeline
  task automatic run_frame(input int pat, input bit gaps, input bit abort);
    int          acc;
    int          step;
    int          n;
    int          f0;
    bit [63:0]   mask;
    bit          v;
    int          idx;
    logic [31:0] re;
    logic [31:0] im;
    exp_t        e;
    acc = 0;
    step = 0;
    mask = '0;
    @(negedge clk);
    start = 1'b1;
    exp_dup_nx = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", longint'(busy), 1);
    while (acc < SIZE) begin
      chk("in_ready_run", longint'(in_ready), 1);
      v = gaps ? ((step % 4) == 0 || (step % 4) == 3) : 1'b1;
      idx = acc;
      re = $urandom;
      im = $urandom;
      case (pat)
        0: begin
          re = 32'(3 * acc);
          im = 32'(-4 * acc);
        end
        2: begin
          if (acc == 0) begin re = 32'h8000_0000; im = 32'h8000_0000; end
          if (acc == 1) begin re = 32'h7FFF_FFFF; im = 32'h0; end
          if (acc == 2) idx = 7;
          if (acc == 3) begin re = 32'hFFFF_FFF0; im = 32'h13; end
        end
        3: idx = int'($urandom_range(0, SIZE - 1));
        default: ;
      endcase
      in_valid = v;
      in_re = re;
      in_im = im;
      in_idx = AW'(idx);
      if (v) begin
        e.addr = ref_addr(idx);
        e.din = ref_mag(re, im);
        e.at = cyc + 3;
        sbq.push_back(e);
        if (mask[e.addr]) exp_dup_nx = 1'b1;
        mask[e.addr] = 1'b1;
        acc++;
      end
      step++;
      @(negedge clk);
    end
    // A 65th bin is offered but must not be taken
    chk("in_ready_full", longint'(in_ready), 0);
    in_valid = 1'b1;
    in_re = $urandom;
    in_im = $urandom;
    in_idx = AW'($urandom_range(0, SIZE - 1));
    if (abort) begin
      #2;
      rst = 1'b0;
      exp_dup_nx = 1'b0;
      n = 0;
      while (sbq.size() > 0 && sbq[$].at > cyc) begin
        void'(sbq.pop_back());
        n++;
      end
      chk("abort_pending", longint'(n), 2);
      #1;
      check_all_zero("abort");
      in_valid = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_wea", longint'(o_wea), 0);
      end
      rst = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk("abort_idle_busy", longint'(busy), 0);
        chk("abort_idle_ready", longint'(in_ready), 0);
      end
      chk("abort_sb_empty", longint'(sbq.size()), 0);
    end else begin
      f0 = frames_seen;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (frames_seen == f0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("frame_done_seen", longint'(frames_seen), longint'(f0 + 1));
      repeat (3) @(negedge clk);
      chk("frame_done_once", longint'(frames_seen), longint'(f0 + 1));
      chk("sb_empty", longint'(sbq.size()), 0);
      chk("busy_idle", longint'(busy), 0);
    end
    $display("frame pat=%0d gaps=%0d abort=%0d accepted=%0d dup=%0d", pat, gaps, abort, acc, exp_dup_nx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    dup_mon_en = 1'b1;
    // in_valid while idle is ignored
    in_valid = 1'b1;
    in_re = 32'd5;
    in_im = 32'd9;
    in_idx = 6'd6;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    chk("dup_after_frame", longint'(dup_err), 1);
    run_frame(3, 1'b1, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    chk("dup_cleared", longint'(dup_err), 0);
    run_frame(0, 1'b0, 1'b1);
    run_frame(2, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
